inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl_pkg.sv | 24 ++
 rtl/inst_fetch_ctrl_queue.sv | 78 +++++++
 rtl/inst_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Contents: fetch FSM state encoding, default reset PC, instruction
// queue entry record (inst + pc + adel = 65 bits).
package inst_fetch_ctrl_pkg;

    localparam logic [31:0]  DEF_RESET_PC = 32'hbfc0_0000;
    localparam int unsigned  INST_W       = 32;
    localparam int unsigned  PC_W         = 32;
    localparam int unsigned  Q_ENTRY_W    = INST_W + PC_W + 1;

    // FETCH: issuing requests; HALT: parked after an address error
    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_e;

    // One instruction-queue entry
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic              adel;
    } q_entry_t;

endpackage

// File: rtl/inst_fetch_ctrl_queue.sv
// inst_queue: circular instruction buffer with up to two enqueues and
// two dequeues per cycle.
// Ports:
//   clk, rst        clock, async active-high reset
//   flush           empty the queue (pointers and count to zero)
//   enq_num         entries written this cycle (0..2)
//   enq_data0/1     first/second entry written at tail/tail+1
//   deq_num         entries requested for removal (3 treated as 2)
//   count           registered occupancy
//   head0/head1     entries at head and head+1
module inst_queue
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [1:0]               enq_num,
    input  q_entry_t                 enq_data0,
    input  q_entry_t                 enq_data1,
    input  logic [1:0]               deq_num,
    output logic [$clog2(DEPTH):0]   count,
    output q_entry_t                 head0,
    output q_entry_t                 head1
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    q_entry_t         mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       deq_lim;

    // Saturate the request at 2 and never remove more than is held
    always_comb begin
        deq_lim = (deq_num == 2'd3) ? 2'd2 : deq_num;
        if (CNT_W'(deq_lim) > count_q) begin
            deq_lim = count_q[1:0];
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(deq_lim);
            tail_q  <= tail_q + PTR_W'(enq_num);
            count_q <= count_q + CNT_W'(enq_num) - CNT_W'(deq_lim);
        end
    end

    // Storage writes; contents need no reset since count gates validity
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (enq_num != 2'd0) begin
                mem[tail_q] <= enq_data0;
            end
            if (enq_num >= 2'd2) begin
                mem[tail_q + PTR_W'(1)] <= enq_data1;
            end
        end
    end

    assign count = count_q;
    assign head0 = mem[head_q];
    assign head1 = mem[head_q + PTR_W'(1)];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction fetch sequencer feeding a dual-issue decode
// stage through an instruction queue.
// Ports:
//   clk, rst                  clock, async active-high reset
//   redirect, redirect_pc     flush queue and restart fetch at redirect_pc
//   inst_sram_en/addr         fetch request (8-byte aligned address)
//   inst_sram_rdata           response for the previous cycle's request
//   deq_num                   instructions consumed by decode (0..2)
//   out_valid1/2, out_inst1/2, out_pc1/2, out_adel1/2
//                             head and second queue entries
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [63:0] inst_sram_rdata,
    input  logic [1:0]  deq_num,
    output logic        out_valid1,
    output logic        out_valid2,
    output logic [31:0] out_inst1,
    output logic [31:0] out_inst2,
    output logic [31:0] out_pc1,
    output logic [31:0] out_pc2,
    output logic        out_adel1,
    output logic        out_adel2
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
    // Headroom for count + 2 reserved + 2 requested without wrapping
    localparam int unsigned CW    = CNT_W + 1;

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [31:0]      fpc_q;
    logic             infl_q;
    logic             infl_single_q;
    logic [31:0]      infl_addr_q;
    logic [CNT_W-1:0] q_count;
    logic             misaligned;
    logic             room_two;
    logic             room_one;
    logic             issue_c;
    logic             adel_c;
    logic [1:0]       enq_num;
    q_entry_t         enq_data0;
    q_entry_t         enq_data1;
    q_entry_t         head0;
    q_entry_t         head1;

    assign inst_sram_addr = {fpc_q[31:3], 3'b000};
    assign misaligned     = (fpc_q[1:0] != 2'b00);

    // Space checks use the registered count; an in-flight pair is reserved
    assign room_two = (CW'(q_count) + (infl_q ? CW'(2) : CW'(0)) + CW'(2))
                      <= CW'(QDEPTH);
    assign room_one = (CW'(q_count) + CW'(1)) <= CW'(QDEPTH);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: address error parks fetch until a redirect
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = ST_FETCH;
        end else if (adel_c) begin
            state_d = ST_HALT;
        end
    end

    // FSM outputs: request issue, address-error entry, queue writes
    always_comb begin
        issue_c   = 1'b0;
        adel_c    = 1'b0;
        enq_num   = 2'd0;
        enq_data0 = '0;
        enq_data1 = '0;
        if (!rst && !redirect && state_q == ST_FETCH) begin
            issue_c = !misaligned && room_two;
            adel_c  = misaligned && !infl_q && room_one;
        end
        // A redirect drops any response arriving this cycle
        if (!redirect && infl_q) begin
            if (infl_single_q) begin
                enq_num   = 2'd1;
                enq_data0 = '{inst: inst_sram_rdata[63:32],
                              pc:   infl_addr_q + 32'd4, adel: 1'b0};
            end else begin
                enq_num   = 2'd2;
                enq_data0 = '{inst: inst_sram_rdata[31:0],
                              pc:   infl_addr_q, adel: 1'b0};
                enq_data1 = '{inst: inst_sram_rdata[63:32],
                              pc:   infl_addr_q + 32'd4, adel: 1'b0};
            end
        end else if (adel_c) begin
            enq_num   = 2'd1;
            enq_data0 = '{inst: 32'd0, pc: fpc_q, adel: 1'b1};
        end
    end

    // Fetch PC and in-flight tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            infl_q        <= 1'b0;
            infl_single_q <= 1'b0;
            infl_addr_q   <= '0;
        end else if (redirect) begin
            fpc_q  <= redirect_pc;
            infl_q <= 1'b0;
        end else begin
            infl_q <= issue_c;
            if (issue_c) begin
                fpc_q         <= inst_sram_addr + 32'd8;
                infl_single_q <= fpc_q[2];
                infl_addr_q   <= inst_sram_addr;
            end
        end
    end

    assign inst_sram_en = issue_c;

    inst_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .enq_num   (enq_num),
        .enq_data0 (enq_data0),
        .enq_data1 (enq_data1),
        .deq_num   (deq_num),
        .count     (q_count),
        .head0     (head0),
        .head1     (head1)
    );

    assign out_valid1 = (q_count != CNT_W'(0));
    assign out_valid2 = (q_count >= CNT_W'(2));
    assign out_inst1  = head0.inst;
    assign out_inst2  = head1.inst;
    assign out_pc1    = head0.pc;
    assign out_pc2    = head1.pc;
    assign out_adel1  = out_valid1 & head0.adel;
    assign out_adel2  = out_valid2 & head1.adel;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a one-cycle-latency SRAM model.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [63:0] inst_sram_rdata;
    logic [1:0]  deq_num;
    logic        out_valid1, out_valid2;
    logic [31:0] out_inst1, out_inst2, out_pc1, out_pc2;
    logic        out_adel1, out_adel2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.QDEPTH(8), .RESET_PC(32'hbfc0_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .deq_num         (deq_num),
        .out_valid1      (out_valid1),
        .out_valid2      (out_valid2),
        .out_inst1       (out_inst1),
        .out_inst2       (out_inst2),
        .out_pc1         (out_pc1),
        .out_pc2         (out_pc2),
        .out_adel1       (out_adel1),
        .out_adel2       (out_adel2)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5a5a_c3c3;
    endfunction

    // SRAM model: data for the address presented in the previous cycle
    logic [31:0] addr_q;
    always @(posedge clk) addr_q <= inst_sram_addr;
    assign inst_sram_rdata = {pat(addr_q + 32'd4), pat(addr_q)};

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first cycle after release
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_num = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_num = 2'd0;
        #1;
        n_checks++; if (inst_sram_en !== 1'b0) $display("FAIL rst_en: got %b want 0", inst_sram_en); else n_pass++;
        n_checks++; if (out_valid1 !== 1'b0) $display("FAIL rst_valid1: got %b want 0", out_valid1); else n_pass++;
        n_checks++; if (out_adel1 !== 1'b0) $display("FAIL rst_adel1: got %b want 0", out_adel1); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (inst_sram_en !== 1'b1) $display("FAIL c1_en: got %b want 1", inst_sram_en); else n_pass++;
        n_checks++; if (inst_sram_addr !== 32'hbfc0_0000) $display("FAIL c1_addr: got %h want bfc00000", inst_sram_addr); else n_pass++;
        next_cyc();
        n_checks++; if (inst_sram_addr !== 32'hbfc0_0008) $display("FAIL c2_addr: got %h want bfc00008", inst_sram_addr); else n_pass++;
        n_checks++; if (out_valid1 !== 1'b0) $display("FAIL c2_valid1: got %b want 0", out_valid1); else n_pass++;
        next_cyc();
        n_checks++; if ({out_valid1, out_valid2} !== 2'b11) $display("FAIL c3_valid: got %b want 11", {out_valid1, out_valid2}); else n_pass++;
        n_checks++; if (out_pc1 !== 32'hbfc0_0000) $display("FAIL c3_pc1: got %h want bfc00000", out_pc1); else n_pass++;
        n_checks++; if (out_pc2 !== 32'hbfc0_0004) $display("FAIL c3_pc2: got %h want bfc00004", out_pc2); else n_pass++;
        n_checks++; if (out_inst1 !== pat(32'hbfc0_0000)) $display("FAIL c3_inst1: got %h want %h", out_inst1, pat(32'hbfc0_0000)); else n_pass++;
        n_checks++; if (out_inst2 !== pat(32'hbfc0_0004)) $display("FAIL c3_inst2: got %h want %h", out_inst2, pat(32'hbfc0_0004)); else n_pass++;
    endtask

    task automatic test_full();
        int reqs = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (inst_sram_en) reqs++;
            next_cyc();
        end
        n_checks++; if (reqs !== 4) $display("FAIL full_reqs: got %0d want 4", reqs); else n_pass++;
        n_checks++; if (inst_sram_en !== 1'b0) $display("FAIL full_en: got %b want 0", inst_sram_en); else n_pass++;
        n_checks++; if ({out_valid1, out_valid2} !== 2'b11) $display("FAIL full_valid: got %b want 11", {out_valid1, out_valid2}); else n_pass++;
        deq_num = 2'd2;
        #1;
        n_checks++; if (inst_sram_en !== 1'b0) $display("FAIL full_deq_en: got %b want 0", inst_sram_en); else n_pass++;
        @(negedge clk);
        deq_num = 2'd0;
        #1;
        n_checks++; if (inst_sram_en !== 1'b1) $display("FAIL full_reen: got %b want 1", inst_sram_en); else n_pass++;
        n_checks++; if (inst_sram_addr !== 32'hbfc0_0020) $display("FAIL full_addr: got %h want bfc00020", inst_sram_addr); else n_pass++;
        n_checks++; if (out_pc1 !== 32'hbfc0_0008) $display("FAIL full_pc1: got %h want bfc00008", out_pc1); else n_pass++;
    endtask

    task automatic test_odd_pc();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hbfc0_0014;
        #1;
        n_checks++; if (inst_sram_en !== 1'b0) $display("FAIL odd_redir_en: got %b want 0", inst_sram_en); else n_pass++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++; if (inst_sram_addr !== 32'hbfc0_0010) $display("FAIL odd_addr: got %h want bfc00010", inst_sram_addr); else n_pass++;
        next_cyc();
        n_checks++; if (inst_sram_addr !== 32'hbfc0_0018) $display("FAIL odd_next_addr: got %h want bfc00018", inst_sram_addr); else n_pass++;
        next_cyc();
        n_checks++; if ({out_valid1, out_valid2} !== 2'b10) $display("FAIL odd_valid: got %b want 10", {out_valid1, out_valid2}); else n_pass++;
        n_checks++; if (out_pc1 !== 32'hbfc0_0014) $display("FAIL odd_pc1: got %h want bfc00014", out_pc1); else n_pass++;
        n_checks++; if (out_inst1 !== pat(32'hbfc0_0014)) $display("FAIL odd_inst1: got %h want %h", out_inst1, pat(32'hbfc0_0014)); else n_pass++;
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        next_cyc();
        redirect = 1'b1; redirect_pc = 32'h8000_1000;
        #1;
        n_checks++; if (inst_sram_en !== 1'b0) $display("FAIL rif_en: got %b want 0", inst_sram_en); else n_pass++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++; if (out_valid1 !== 1'b0) $display("FAIL rif_valid_a: got %b want 0", out_valid1); else n_pass++;
        n_checks++; if (inst_sram_addr !== 32'h8000_1000 || inst_sram_en !== 1'b1) $display("FAIL rif_addr: got %b/%h want 1/80001000", inst_sram_en, inst_sram_addr); else n_pass++;
        next_cyc();
        n_checks++; if (out_valid1 !== 1'b0) $display("FAIL rif_valid_b: got %b want 0", out_valid1); else n_pass++;
        next_cyc();
        n_checks++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'h8000_1000) $display("FAIL rif_pc1: got %b/%h want 1/80001000", out_valid1, out_pc1); else n_pass++;
    endtask

    task automatic test_misaligned();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hbfc0_0002;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++; if (inst_sram_en !== 1'b0) $display("FAIL adel_en_a: got %b want 0", inst_sram_en); else n_pass++;
        next_cyc();
        n_checks++; if ({out_valid1, out_valid2} !== 2'b10) $display("FAIL adel_valid: got %b want 10", {out_valid1, out_valid2}); else n_pass++;
        n_checks++; if (out_adel1 !== 1'b1) $display("FAIL adel_flag: got %b want 1", out_adel1); else n_pass++;
        n_checks++; if (out_pc1 !== 32'hbfc0_0002) $display("FAIL adel_pc1: got %h want bfc00002", out_pc1); else n_pass++;
        n_checks++; if (out_inst1 !== 32'h0) $display("FAIL adel_inst1: got %h want 00000000", out_inst1); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (inst_sram_en !== 1'b0) $display("FAIL adel_halt_en: got %b want 0 (cycle %0d)", inst_sram_en, i); else n_pass++;
            next_cyc();
        end
        redirect = 1'b1; redirect_pc = 32'hbfc0_0100;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc0_0100) $display("FAIL adel_restart: got %b/%h want 1/bfc00100", inst_sram_en, inst_sram_addr); else n_pass++;
        n_checks++; if (out_valid1 !== 1'b0) $display("FAIL adel_flushed: got %b want 0", out_valid1); else n_pass++;
    endtask

    task automatic test_enq2_deq1_wrap();
        logic [31:0] exp_pc;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h0000_1004;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        next_cyc();
        next_cyc();
        n_checks++; if ({out_valid1, out_valid2} !== 2'b10 || out_pc1 !== 32'h1004) $display("FAIL ed_first: got %b/%h want 10/00001004", {out_valid1, out_valid2}, out_pc1); else n_pass++;
        next_cyc();
        // count is 3 here and a pair is arriving
        n_checks++; if (out_valid2 !== 1'b1 || out_pc2 !== 32'h1008) $display("FAIL ed_cnt3: got %b/%h want 1/00001008", out_valid2, out_pc2); else n_pass++;
        deq_num = 2'd1;
        next_cyc();
        n_checks++; if (out_pc1 !== 32'h1008 || out_pc2 !== 32'h100c) $display("FAIL ed_after: got %h/%h want 00001008/0000100c", out_pc1, out_pc2); else n_pass++;
        n_checks++; if (inst_sram_en !== 1'b1) $display("FAIL ed_cnt4_en: got %b want 1", inst_sram_en); else n_pass++;
        deq_num = 2'd2;
        exp_pc = 32'h1010;
        for (int i = 0; i < 200 && exp_pc < 32'h10a8; i++) begin
            next_cyc();
            if (out_valid1) begin
                n_checks++; if (out_pc1 !== exp_pc || out_inst1 !== pat(exp_pc)) $display("FAIL wrap_pc1: got %h/%h want %h/%h", out_pc1, out_inst1, exp_pc, pat(exp_pc)); else n_pass++;
                if (out_valid2) begin
                    n_checks++; if (out_pc2 !== exp_pc + 32'd4) $display("FAIL wrap_pc2: got %h want %h", out_pc2, exp_pc + 32'd4); else n_pass++;
                    exp_pc = exp_pc + 32'd8;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        n_checks++; if (exp_pc < 32'h10a8) $display("FAIL wrap_progress: got %h want >= 000010a8", exp_pc); else n_pass++;
        deq_num = 2'd0;
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        next_cyc();
        next_cyc();
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid1 !== 1'b0 || inst_sram_en !== 1'b0) $display("FAIL mid_rst: got %b/%b want 0/0", out_valid1, inst_sram_en); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc0_0000) $display("FAIL mid_first: got %b/%h want 1/bfc00000", inst_sram_en, inst_sram_addr); else n_pass++;
        next_cyc();
        n_checks++; if (out_valid1 !== 1'b0) $display("FAIL mid_discard: got %b want 0", out_valid1); else n_pass++;
        next_cyc();
        n_checks++; if (out_valid1 !== 1'b1 || out_pc1 !== 32'hbfc0_0000) $display("FAIL mid_pc1: got %b/%h want 1/bfc00000", out_valid1, out_pc1); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_num = 2'd0;
        test_reset();
        test_full();
        test_odd_pc();
        test_redirect_inflight();
        test_misaligned();
        test_enq2_deq1_wrap();
        test_reset_midfetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
